lt24_onchip_ram_dp: RTL and testbench

Parametrised dual-port on-chip RAM with two independent Avalon-MM slaves, s1 and s2, sharing one clock. It is the successor to the single-port, unregistered-output LT24 scratch RAM. It adds:
- configurable data width, depth and read latency;
- explicit read/readdatavalid pipelining;
- cross-port write-to-read forwarding;
- deterministic write-collision resolution, with a saturating collision counter.

The LT24 frame/cache path uses it as a line buffer between the CPU (s1) and the pixel DMA (s2).

---
 rtl/lt24_onchip_ram_dp_pkg.sv | 30 +++
 rtl/lt24_onchip_ram_dp_if.sv | 26 ++
 rtl/lt24_ram_tdp_core.sv | 35 +++
 rtl/lt24_onchip_ram_dp.sv | 150 +++++++++++++++
 tb/tb_lt24_onchip_ram_dp.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lt24_onchip_ram_dp_pkg.sv
// Shared helpers for the LT24 on-chip RAM: parameter checks and byte-lane merge.
package lt24_mem_pkg;

  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  typedef logic [MAX_DATA_W-1:0] wide_data_t;
  typedef logic [MAX_BE_W-1:0]   wide_be_t;

  function automatic int unsigned calc_be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic bit latency_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Lanes with be=1 take new_d, the rest keep old_d; callers cast to/from the wide type.
  function automatic wide_data_t byte_merge(input wide_data_t old_d,
                                            input wide_data_t new_d,
                                            input wide_be_t   be);
    wide_data_t r;
    r = old_d;
    for (int unsigned i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) r[8*i +: 8] = new_d[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/lt24_onchip_ram_dp_if.sv
// One Avalon-MM slave port of the LT24 on-chip RAM.
interface lt24_onchip_ram_dp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned BE_W = lt24_mem_pkg::calc_be_w(DATA_W);

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/lt24_ram_tdp_core.sv
// Inferred true-dual-port byte-enabled RAM; reads return pre-write (old) data.
module lt24_ram_tdp_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic [BE_W-1:0]   a_be,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_q,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [BE_W-1:0]   b_be,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_q
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Port A is written last so it wins a same-address clash; the top already drops B then.
  always_ff @(posedge clk) begin
    if (en) begin
      a_q <= mem[a_addr];
      b_q <= mem[b_addr];
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (b_we && b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        if (a_we && a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/lt24_onchip_ram_dp.sv
// Dual-port LT24 line-buffer RAM: access decode, cross-port forwarding, read pipeline, collision count.
module lt24_onchip_ram_dp
  import lt24_mem_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned BE_W         = calc_be_w(DATA_W),
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  reset_req,
  lt24_onchip_ram_dp_if.slave   s1,
  lt24_onchip_ram_dp_if.slave   s2,
  output logic [CNT_W-1:0]      collision_count
);

  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("lt24_onchip_ram_dp: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_W % 8 != 0) || (BE_W != calc_be_w(DATA_W)) || (DATA_W > MAX_DATA_W)) begin : g_bad_width
    $error("lt24_onchip_ram_dp: illegal DATA_W/BE_W");
  end

  logic              en;
  logic              coll;
  logic [1:0]        wr_raw, wr, rd, rv, v1, fwd_hit;
  logic [ADDR_W-1:0] addr     [2];
  logic [BE_W-1:0]   be       [2];
  logic [BE_W-1:0]   fwd_be   [2];
  logic [DATA_W-1:0] wdata    [2];
  logic [DATA_W-1:0] fwd_data [2];
  logic [DATA_W-1:0] q        [2];
  logic [DATA_W-1:0] merged   [2];
  logic [DATA_W-1:0] out_q    [2];
  logic [DATA_W-1:0] rdata    [2];

  assign en = clken & ~reset_req;

  always_comb begin
    addr[0]   = s1.address;    addr[1]   = s2.address;
    be[0]     = s1.byteenable; be[1]     = s2.byteenable;
    wdata[0]  = s1.writedata;  wdata[1]  = s2.writedata;
    wr_raw[0] = s1.chipselect & s1.write & en;
    wr_raw[1] = s2.chipselect & s2.write & en;
    rd[0]     = s1.chipselect & s1.read & en & ~s1.write;
    rd[1]     = s2.chipselect & s2.read & en & ~s2.write;
  end

  assign coll = wr_raw[0] & wr_raw[1] & (addr[0] == addr[1]);
  assign wr   = {wr_raw[1] & ~coll, wr_raw[0]};

  lt24_ram_tdp_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BE_W  (BE_W)
  ) u_core (
    .clk    (clk),
    .en     (clken),
    .a_addr (addr[0]),
    .a_we   (wr[0]),
    .a_be   (be[0]),
    .a_wdata(wdata[0]),
    .a_q    (q[0]),
    .b_addr (addr[1]),
    .b_we   (wr[1]),
    .b_be   (be[1]),
    .b_wdata(wdata[1]),
    .b_q    (q[1])
  );

  // The RAM returns old data on a cross-port same-address hit; remember the other port's write to patch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1      <= '0;
      fwd_hit <= '0;
      for (int unsigned p = 0; p < 2; p++) begin
        fwd_be[p]   <= '0;
        fwd_data[p] <= '0;
      end
    end else if (clken) begin
      v1 <= rd;
      for (int unsigned p = 0; p < 2; p++) begin
        fwd_hit[p]  <= wr[p^1] & rd[p] & (addr[p^1] == addr[p]);
        fwd_be[p]   <= be[p^1];
        fwd_data[p] <= wdata[p^1];
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      merged[p] = DATA_W'(byte_merge(wide_data_t'(q[p]), wide_data_t'(fwd_data[p]),
                                     wide_be_t'(fwd_hit[p] ? fwd_be[p] : '0)));
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    // out_q only remembers the last delivered word so readdata holds between pulses.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned p = 0; p < 2; p++) out_q[p] <= '0;
      end else if (clken) begin
        for (int unsigned p = 0; p < 2; p++) begin
          if (v1[p]) out_q[p] <= merged[p];
        end
      end
    end

    always_comb begin
      rv = v1;
      for (int unsigned p = 0; p < 2; p++) rdata[p] = v1[p] ? merged[p] : out_q[p];
    end
  end else begin : g_lat2
    logic [1:0] v2;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v2 <= '0;
        for (int unsigned p = 0; p < 2; p++) out_q[p] <= '0;
      end else if (clken) begin
        v2 <= v1;
        for (int unsigned p = 0; p < 2; p++) begin
          if (v1[p]) out_q[p] <= merged[p];
        end
      end
    end

    always_comb begin
      rv = v2;
      for (int unsigned p = 0; p < 2; p++) rdata[p] = out_q[p];
    end
  end

  assign s1.readdata      = rdata[0];
  assign s1.readdatavalid = rv[0];
  assign s2.readdata      = rdata[1];
  assign s2.readdatavalid = rv[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision_count <= '0;
    end else if (clken && coll && (collision_count != '1)) begin
      collision_count <= collision_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lt24_onchip_ram_dp.sv
// Scoreboard bench: two DUTs (latency 1 / 16-bit counter, latency 2 / 2-bit counter) on identical stimulus.
module tb_lt24_onchip_ram_dp;

  typedef struct {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } port_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, clken, reset_req;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  lt24_onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(8)) a1 ();
  lt24_onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(8)) a2 ();
  lt24_onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(8)) b1 ();
  lt24_onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(8)) b2 ();

  assign b1.address = a1.address;  assign b1.chipselect = a1.chipselect;
  assign b1.read    = a1.read;     assign b1.write      = a1.write;
  assign b1.byteenable = a1.byteenable; assign b1.writedata = a1.writedata;
  assign b2.address = a2.address;  assign b2.chipselect = a2.chipselect;
  assign b2.read    = a2.read;     assign b2.write      = a2.write;
  assign b2.byteenable = a2.byteenable; assign b2.writedata = a2.writedata;

  lt24_onchip_ram_dp #(
    .DATA_W(32), .ADDR_W(8), .READ_LATENCY(1), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1(a1.slave), .s2(a2.slave), .collision_count(cnt_a)
  );

  lt24_onchip_ram_dp #(
    .DATA_W(32), .ADDR_W(8), .READ_LATENCY(2), .CNT_W(2)
  ) u_dut_b (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1(b1.slave), .s2(b2.slave), .collision_count(cnt_b)
  );

  logic        rv_o [4];
  logic [31:0] rd_o [4];
  assign rv_o[0] = a1.readdatavalid; assign rd_o[0] = a1.readdata;
  assign rv_o[1] = a2.readdatavalid; assign rd_o[1] = a2.readdata;
  assign rv_o[2] = b1.readdatavalid; assign rd_o[2] = b1.readdata;
  assign rv_o[3] = b2.readdatavalid; assign rd_o[3] = b2.readdata;

  // Reference state: word array, expected-read queues indexed {dut_a.s1, dut_a.s2, dut_b.s1, dut_b.s2}.
  logic [31:0] ref_mem [256];
  int          ref_cnt_a = 0, ref_cnt_b = 0;
  exp_t        exp_q [4][$];
  int          ecnt = 0;
  int          n_cmp = 0, n_bad = 0;

  always @(posedge clk) if (!reset && clken) ecnt <= ecnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // A read sees every write of its own cycle, and s1 entirely overrides a same-address s2 write.
  task automatic model(input port_t p1, input port_t p2);
    bit w1, w2, r1, r2, coll;
    int n;
    n    = ecnt + 1;
    w1   = p1.cs && p1.wr;
    w2   = p2.cs && p2.wr;
    r1   = p1.cs && p1.rd && !p1.wr;
    r2   = p2.cs && p2.rd && !p2.wr;
    coll = w1 && w2 && (p1.addr == p2.addr);
    if (w2 && !coll) ref_mem[p2.addr] = lane_merge(ref_mem[p2.addr], p2.wd, p2.be);
    if (w1)          ref_mem[p1.addr] = lane_merge(ref_mem[p1.addr], p1.wd, p1.be);
    if (coll) begin
      if (ref_cnt_a < 65535) ref_cnt_a++;
      if (ref_cnt_b < 3)     ref_cnt_b++;
    end
    if (r1) begin
      exp_q[0].push_back('{due: n,     data: ref_mem[p1.addr]});
      exp_q[2].push_back('{due: n + 1, data: ref_mem[p1.addr]});
    end
    if (r2) begin
      exp_q[1].push_back('{due: n,     data: ref_mem[p2.addr]});
      exp_q[3].push_back('{due: n + 1, data: ref_mem[p2.addr]});
    end
  endtask

  task automatic step(input port_t p1, input port_t p2, input logic ce, input logic rr);
    a1.chipselect = p1.cs; a1.read = p1.rd; a1.write = p1.wr;
    a1.address = p1.addr;  a1.byteenable = p1.be; a1.writedata = p1.wd;
    a2.chipselect = p2.cs; a2.read = p2.rd; a2.write = p2.wr;
    a2.address = p2.addr;  a2.byteenable = p2.be; a2.writedata = p2.wd;
    clken = ce;
    reset_req = rr;
    if (ce && !rr) model(p1, p2);
    @(negedge clk);
    #1;
  endtask

  function automatic port_t pi();
    return '{cs: 1'b0, rd: 1'b0, wr: 1'b0, addr: 8'h00, be: 4'h0, wd: 32'h0};
  endfunction
  function automatic port_t pw(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    return '{cs: 1'b1, rd: 1'b0, wr: 1'b1, addr: a, be: be, wd: d};
  endfunction
  function automatic port_t pr(input logic [7:0] a);
    return '{cs: 1'b1, rd: 1'b1, wr: 1'b0, addr: a, be: 4'h0, wd: 32'h0};
  endfunction
  function automatic port_t prand();
    port_t p;
    p.cs   = ($urandom_range(0, 9) != 0);
    p.rd   = 1'($urandom_range(0, 1));
    p.wr   = 1'($urandom_range(0, 1));
    p.addr = 8'h10 + 8'($urandom_range(0, 3));
    p.be   = 4'($urandom_range(0, 15));
    p.wd   = $urandom;
    return p;
  endfunction

  // Monitor: fresh outputs after each enabled edge are scored; stalled cycles must hold.
  logic        snap_v [4];
  logic [31:0] snap_d [4];
  logic [31:0] last_rd [4];
  logic [15:0] snap_ca;
  logic [1:0]  snap_cb;
  int          last_ecnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_ecnt = ecnt;
      for (int k = 0; k < 4; k++) begin
        last_rd[k] = '0; snap_v[k] = 1'b0; snap_d[k] = '0;
      end
      snap_ca = '0;
      snap_cb = '0;
    end else if (ecnt != last_ecnt) begin
      last_ecnt = ecnt;
      for (int k = 0; k < 4; k++) begin
        if (exp_q[k].size() > 0 && exp_q[k][0].due == ecnt) begin
          e = exp_q[k].pop_front();
          check($sformatf("valid[%0d]", k), 32'(rv_o[k]), 32'd1);
          check($sformatf("rdata[%0d]", k), rd_o[k], e.data);
          last_rd[k] = e.data;
        end else begin
          check($sformatf("idle_valid[%0d]", k), 32'(rv_o[k]), 32'd0);
          check($sformatf("hold_rdata[%0d]", k), rd_o[k], last_rd[k]);
        end
        snap_v[k] = rv_o[k];
        snap_d[k] = rd_o[k];
      end
      check("count_a", 32'(cnt_a), 32'(ref_cnt_a));
      check("count_b", 32'(cnt_b), 32'(ref_cnt_b));
      snap_ca = cnt_a;
      snap_cb = cnt_b;
    end else begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("stall_valid[%0d]", k), 32'(rv_o[k]), 32'(snap_v[k]));
        check($sformatf("stall_rdata[%0d]", k), rd_o[k], snap_d[k]);
      end
      check("stall_count_a", 32'(cnt_a), 32'(snap_ca));
      check("stall_count_b", 32'(cnt_b), 32'(snap_cb));
    end
  end

  task automatic async_reset();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_valid[%0d]", k), 32'(rv_o[k]), 32'd0);
      check($sformatf("rst_rdata[%0d]", k), rd_o[k], 32'd0);
      exp_q[k].delete();
    end
    check("rst_count_a", 32'(cnt_a), 32'd0);
    check("rst_count_b", 32'(cnt_b), 32'd0);
    ref_cnt_a = 0;
    ref_cnt_b = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clken = 1'b1;
    reset_req = 1'b0;
    a1.chipselect = 1'b0; a1.read = 1'b0; a1.write = 1'b0;
    a1.address = '0; a1.byteenable = '0; a1.writedata = '0;
    a2.chipselect = 1'b0; a2.read = 1'b0; a2.write = 1'b0;
    a2.address = '0; a2.byteenable = '0; a2.writedata = '0;
    @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("por_valid[%0d]", k), 32'(rv_o[k]), 32'd0);
      check($sformatf("por_rdata[%0d]", k), rd_o[k], 32'd0);
    end
    check("por_count_a", 32'(cnt_a), 32'd0);
    check("por_count_b", 32'(cnt_b), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Preload every word, two per cycle.
    for (int i = 0; i < 128; i++) step(pw(8'(2*i), 4'hF, $urandom), pw(8'(2*i+1), 4'hF, $urandom), 1'b1, 1'b0);

    step(pw(8'h10, 4'hF, 32'hDEADBEEF), pi(), 1'b1, 1'b0);
    step(pr(8'h10), pi(), 1'b1, 1'b0);
    step(pw(8'h20, 4'hF, 32'h11223344), pi(), 1'b1, 1'b0);
    step(pi(), pw(8'h20, 4'h5, 32'hAABBCCDD), 1'b1, 1'b0);
    step(pr(8'h20), pi(), 1'b1, 1'b0);
    step(pw(8'h30, 4'hF, 32'h0), pi(), 1'b1, 1'b0);
    step(pw(8'h30, 4'h3, 32'h12345678), pr(8'h30), 1'b1, 1'b0);
    step(pi(), pr(8'h30), 1'b1, 1'b0);
    step(pr(8'h30), pw(8'h30, 4'hC, 32'hCAFEF00D), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(pw(8'h40, 4'hF, 32'h1), pw(8'h40, 4'hF, 32'h2), 1'b1, 1'b0);
    step(pr(8'h40), pr(8'h40), 1'b1, 1'b0);
    step(pi(), pi(), 1'b1, 1'b0);

    step(pr(8'h10), pr(8'h20), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(pi(), pi(), 1'b0, 1'b0);
    step(pi(), pi(), 1'b1, 1'b0);
    step(pi(), pi(), 1'b1, 1'b0);
    step(pr(8'h10), pr(8'h10), 1'b1, 1'b1);
    step(pw(8'h10, 4'hF, 32'h55555555), pw(8'h20, 4'hF, 32'h66666666), 1'b1, 1'b1);
    step(pr(8'h10), pr(8'h20), 1'b1, 1'b0);
    step(pi(), pi(), 1'b1, 1'b0);
    step(pi(), pi(), 1'b1, 1'b0);

    step(pr(8'h10), pr(8'h30), 1'b1, 1'b0);
    async_reset();
    step(pr(8'h20), pr(8'h40), 1'b1, 1'b0);
    step(pr(8'h30), pi(), 1'b1, 1'b0);
    step(pi(), pi(), 1'b1, 1'b0);

    for (int i = 0; i < 600; i++) begin
      step(prand(), prand(), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 9) == 0));
    end

    for (int i = 0; i < 4; i++) step(pi(), pi(), 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) check($sformatf("drained[%0d]", k), 32'(exp_q[k].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
